// File: rtl/fpcvt_sched.sv
// fpcvt_sched: round-robin scheduler sharing one FPCVT converter among
// N_REQ requesters. Also contains the fpcvt converter module it instantiates.
//
// Ports (fpcvt_sched):
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     per-requester operand valid
//   req_data      packed operands, requester i on [13*i+12 : 13*i]
//   req_ready     one-hot accept pulse (IDLE only)
//   resp_valid    result presented
//   resp_ready    consumer accepts the result
//   resp_id       index of the requester owning the result
//   resp_float    {S, E[2:0], F[4:0]}
//   busy          FSM not in IDLE
//   sat_cnt       saturated-result count, sticks at 255
//
// Ports (fpcvt):
//   din           13-bit two's-complement operand
//   s, e, f       sign, 3-bit exponent, 5-bit significand (value = F * 2^E)

module fpcvt (
  input  logic [12:0] din,
  output logic        s,
  output logic [2:0]  e,
  output logic [4:0]  f
);

  logic [12:0] mag;
  logic [3:0]  p;
  logic [5:0]  sh;
  logic [5:0]  sum;
  logic [3:0]  ex;

  // Magnitude, leading-one search, round on the bit below the significand.
  always_comb begin
    s   = din[12];
    e   = 3'd0;
    f   = 5'd0;
    sh  = 6'd0;
    sum = 6'd0;
    ex  = 4'd0;
    // -4096 negates to 13'h1000, which is still the correct unsigned magnitude
    mag = din[12] ? (13'd0 - din) : din;
    p   = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (mag[i]) begin
        p = 4'(i);
      end else begin
        p = p;
      end
    end
    if (p <= 4'd4) begin
      // small magnitudes are exact with E=0
      e = 3'd0;
      f = mag[4:0];
    end else begin
      // sh[5:1] is the 5-bit significand, sh[0] the rounding bit
      sh  = 6'(mag >> (p - 4'd5));
      sum = {1'b0, sh[5:1]} + {5'd0, sh[0]};
      // significand overflow after rounding bumps the exponent
      ex  = p - 4'd4 + {3'd0, sum[5]};
      if (ex > 4'd7) begin
        e = 3'd7;
        f = 5'd31;
      end else begin
        e = ex[2:0];
        f = sum[5] ? 5'b10000 : sum[4:0];
      end
    end
  end

endmodule

module fpcvt_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [13*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [8:0]           resp_float,
  output logic                 busy,
  output logic [7:0]           sat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [12:0]     op_q, op_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [8:0]      resp_float_q, resp_float_d;
  logic [7:0]      sat_cnt_q, sat_cnt_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [12:0]     gnt_data;
  logic            cv_s;
  logic [2:0]      cv_e;
  logic [4:0]      cv_f;

  // The converter only ever sees the registered operand.
  fpcvt u_fpcvt (
    .din (op_q),
    .s   (cv_s),
    .e   (cv_e),
    .f   (cv_f)
  );

  // Round-robin search upward from rr_ptr, wrapping at N_REQ-1.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      idx_w = ID_W'(idx);
      if (!gnt_found && req_valid[idx_w]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_w;
      end else begin
        gnt_found = gnt_found;
      end
    end
  end

  // Operand mux and one-hot accept pulse for the granted requester.
  always_comb begin
    gnt_data  = 13'd0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == ID_W'(k)) begin
        gnt_data     = req_data[13*k +: 13];
        req_ready[k] = !rst && (state_q == S_IDLE) && gnt_found;
      end else begin
        req_ready[k] = 1'b0;
      end
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_d         = op_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_float_d = resp_float_q;
    sat_cnt_d    = sat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          op_d     = gnt_data;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          state_d  = S_CONV;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CONV: begin
        resp_float_d = {cv_s, cv_e, cv_f};
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
        // saturation is identified by the output code, either sign
        if ({cv_e, cv_f} == 8'hFF && sat_cnt_q != 8'hFF) begin
          sat_cnt_d = sat_cnt_q + 8'd1;
        end else begin
          sat_cnt_d = sat_cnt_q;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d      = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      op_q         <= 13'd0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_float_q <= 9'd0;
      sat_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_q         <= op_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_float_q <= resp_float_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_float = resp_float_q;
  assign busy       = (state_q != S_IDLE);
  assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_fpcvt_sched.sv
// tb_fpcvt_sched: scoreboard bench for fpcvt_sched. A grant monitor pushes the
// hand-computed expected result whenever a requester is accepted; a response
// monitor pops and compares on every resp_valid/resp_ready handshake.

module tb_fpcvt_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [51:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [8:0]  resp_float;
  logic        busy;
  logic [7:0]  sat_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [8:0]  exp_tab [4];
  logic [10:0] sb_q [$];
  bit          abort_next = 1'b0;

  fpcvt_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_float (resp_float),
    .busy       (busy),
    .sat_cnt    (sat_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor: check the accept pulse and queue the expected response.
  always @(negedge clk) begin
    int gi;
    if (!rst && req_ready != 4'b0000) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
      chk("grant_onehot_valid",
          {31'd0, $onehot(req_ready) && ((req_ready & req_valid) == req_ready)}, 32'd1);
      if (abort_next) abort_next = 1'b0;
      else sb_q.push_back({gi[1:0], exp_tab[gi]});
    end
  end

  // Response monitor: pop and compare on each handshake.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got id %0d float %h expected none", resp_id, resp_float);
      end else begin
        e = sb_q.pop_front();
        chk("resp_id", resp_id, e[10:9]);
        chk("resp_float", resp_float, e[8:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int id, input logic [12:0] d, input logic [8:0] ef);
    exp_tab[id] = ef;
    req_data[13*id +: 13] = d;
  endtask

  task automatic wait_grant(input int id, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (req_ready[id]) seen = 1'b1;
    end
    chk("grant_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !resp_valid) done = 1'b1;
    end
    chk("drain", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int id, input logic [12:0] d, input logic [8:0] ef);
    set_req(id, d, ef);
    req_valid[id] = 1'b1;
    wait_grant(id, 50);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    drain();
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int prev_c;
    int ng;
    logic [1:0] hid;
    logic [8:0] hf;

    rst        = 1'b1;
    req_valid  = 4'b0000;
    req_data   = 52'd0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_tab[i] = 9'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_float", resp_float, 0);
    rst = 1'b0;

    // First transaction latency: 422 -> 9'h09A
    set_req(0, 13'd422, 9'h09A);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t0_req_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_resp_valid", resp_valid, 0);
    @(negedge clk);
    chk("t2_busy", busy, 1);
    chk("t2_resp_valid", resp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_busy", busy, 0);
    chk("t3_resp_valid", resp_valid, 0);
    @(posedge clk); #1;

    // Single-requester vectors on requester 2
    do_req(2, 13'h0000, 9'h000);
    do_req(2, 13'h1E5A, 9'h19A);
    chk("sat_after_neg", sat_cnt, 0);
    do_req(2, 13'h0FFF, 9'h0FF);
    chk("sat_after_0fff", sat_cnt, 1);
    do_req(2, 13'h1000, 9'h1FF);
    chk("sat_after_1000", sat_cnt, 2);
    do_req(2, 13'd32, 9'h030);
    do_req(2, 13'd63, 9'h050);

    // Round robin with all requesters continuously valid
    reset_pulse();
    set_req(0, 13'd422, 9'h09A);
    set_req(1, 13'd63, 9'h050);
    set_req(2, 13'h1E5A, 9'h19A);
    set_req(3, 13'd31, 9'h01F);
    req_valid = 4'b1111;
    ng = 0;
    prev_c = 0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        chk("rr_order", req_ready, 4'b0001 << (ng % 4));
        if (ng > 0) chk("rr_spacing", cyc - prev_c, 3);
        prev_c = cyc;
        ng++;
      end
    end
    chk("rr_grants", ng, 6);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    drain();

    // Backpressure with requester 1 pending (rr_ptr now 2, so 0 wins first)
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    @(negedge clk);
    chk("bp_first_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
    chk("bp_resp_valid", resp_valid, 1);
    hid = resp_id;
    hf  = resp_float;
    chk("bp_id_value", hid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_id", resp_id, hid);
      chk("bp_hold_float", resp_float, hf);
      chk("bp_no_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_no_grant", req_ready, 0);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // Reset during CONV
    do_req(2, 13'h0FFF, 9'h0FF);
    chk("abort_sat_pre", sat_cnt, 1);
    abort_next = 1'b1;
    set_req(3, 13'h0FFF, 9'h0FF);
    req_valid[3] = 1'b1;
    wait_grant(3, 50);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sat", sat_cnt, 0);
    chk("abort_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_sat_release", sat_cnt, 0);
    @(negedge clk);
    chk("abort_first_grant", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    drain();
    chk("abort_sat_after", sat_cnt, 1);

    // Saturation counter ceiling
    reset_pulse();
    for (int n = 1; n <= 255; n++) begin
      do_req(0, 13'h0FFF, 9'h0FF);
      if (n == 254) chk("sat_254", sat_cnt, 254);
    end
    chk("sat_255", sat_cnt, 255);
    do_req(0, 13'h0FFF, 9'h0FF);
    chk("sat_256_hold", sat_cnt, 255);
    do_req(1, 13'h1000, 9'h1FF);
    chk("sat_257_hold", sat_cnt, 255);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpcvt_sched.md
# fpcvt_sched

Round-robin scheduler that shares one FPCVT converter (13-bit two's-complement to sign/3-bit exponent/5-bit significand) among several requesters. It sits between the requesting blocks and a single FPCVT instance. It accepts one operand at a time with a valid/ready handshake and registers the operand into the converter. It returns the registered result, tagged with the requester index, on a response channel that supports backpressure. It also counts saturated conversions.

## Interface
- N_REQ, default 4: number of requesters, legal range 2..8.
- ID_W, default 2: width of resp_id. Must equal clog2(N_REQ).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  bit i high means requester i presents an operand.
- req_data  in  13*N_REQ  operand of requester i is on bits [13*i+12 : 13*i].
- req_ready  out  N_REQ  one-hot pulse that accepts requester i's operand.
- resp_valid  out  1  a result is presented.
- resp_ready  in  1  the consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_float  out  9  converted value {S, E[2:0], F[4:0]}.
- busy  out  1  high in any state other than IDLE.
- sat_cnt  out  8  number of saturated results. Stops at 255 and does not wrap.

## Operation
- The block instantiates one FPCVT internally. The converter input is driven only from the internal operand register op_q[12:0].
- The FSM has three states: IDLE, CONV and RESP.
- IDLE:
  - If req_valid is nonzero, grant the first requester with req_valid high, searching upward from the pointer rr_ptr and wrapping from N_REQ-1 to 0.
  - In the same cycle, drive req_ready[g] high, load op_q with the granted operand, load id_q with g, set rr_ptr to (g+1) mod N_REQ, and go to CONV.
  - If req_valid is zero, stay in IDLE and hold req_ready at 0.
- CONV: capture the FPCVT outputs {S,E,F} into resp_float and id_q into resp_id. Set resp_valid and go to RESP.
  - A saturated result is E=111 and F=11111 with either sign. On a saturated result, increment sat_cnt unless it is already 255.
- RESP:
  - Hold resp_valid, resp_id and resp_float stable while resp_ready is low.
  - When resp_valid and resp_ready are both high, clear resp_valid and go to IDLE.
  - No new request is accepted in the handshake cycle.
- req_ready is high only in IDLE, only on the granted bit, and for exactly one cycle per grant.
- A requester may drop req_valid before it is granted. The block samples req_valid only in IDLE.
- Requests that arrive in CONV or RESP wait. Requesters hold req_valid and req_data until they receive req_ready.
- The arithmetic is exactly FPCVT's: rounding on the sixth significand bit, exponent carry on significand overflow, and saturation to E=111/F=11111. The input 13'h1000 maps to 9'h1FF. The scheduler never changes converter results.

## Timing
- Reset values: state IDLE, rr_ptr 0, op_q 0, id_q 0, req_ready 0, resp_valid 0, resp_id 0, resp_float 0, busy 0, sat_cnt 0.
- Latency: the grant occurs in cycle t. resp_valid rises in cycle t+2 (registered output). With resp_ready held high, the next grant is possible at t+3, so peak throughput is one conversion per 3 cycles.
- Backpressure: each cycle that resp_ready is low in RESP extends the transaction by one cycle. The outputs do not change during that time.
- Reset asserted mid-operation, in any state, returns every register to its reset value immediately:
  - an in-flight or pending response is discarded;
  - resp_valid drops without a handshake;
  - sat_cnt clears.
- The first grant after reset release needs req_valid to be seen in IDLE on a clock edge after rst is low.
- The rr_ptr wrap is (N_REQ-1)+1 → 0.
- The rr_ptr update happens only on a grant. Idle cycles do not advance it.

## Test plan
- Reset release; req 0 with data 13'd422; resp_ready=1:
  - req_ready=0001 in cycle t;
  - resp_valid in cycle t+2 with resp_id=0 and resp_float=9'h09A;
  - busy is high in cycles t+1 and t+2.
- Single-requester operands on requester 2, with expected results:
  - 13'h0000 → 9'h000
  - 13'h1E5A (-422) → 9'h19A
  - 13'h0FFF → 9'h0FF (sat_cnt=1)
  - 13'h1000 → 9'h1FF (sat_cnt=2)
  - all with resp_id=2.
- All four req_valid held high continuously; resp_ready=1 → grant order 0,1,2,3,0,1 at 3-cycle spacing, and resp_id follows the same sequence.
- Hold resp_ready=0 for 5 cycles during RESP with req 1 pending:
  - resp_float and resp_id stay stable;
  - req_ready stays 0;
  - req 1 is granted on the cycle after the handshake.
- Assert rst in the CONV cycle, then release; req 3 is valid:
  - resp_valid never rises for the aborted operand;
  - after release, req 3 is granted first (rr_ptr=0 → search 0..3);
  - sat_cnt is 0.
- Send 256 saturated conversions (13'h0FFF) → sat_cnt reads 255 and stays 255 on the next saturated result.
